// File: rtl/gb_ppu_pkg.sv
// Shared types and constants for the PPU tile fetch path: fetcher states,
// VRAM base offsets, CGB attribute bit positions and the pixel field layout.
package gb_ppu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TILE_NUM,
        ST_TILE_ATTR,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_PUSH
    } fetch_state_e;

    localparam logic [12:0] MAP_BASE_0       = 13'h1800;
    localparam logic [12:0] MAP_BASE_1       = 13'h1C00;
    localparam logic [12:0] TILE_BASE_UNSIGN = 13'h0000;
    localparam logic [12:0] TILE_BASE_SIGNED = 13'h1000;

    localparam int ATTR_PAL_LSB = 0;
    localparam int ATTR_BANK    = 3;
    localparam int ATTR_XFLIP   = 5;
    localparam int ATTR_YFLIP   = 6;
    localparam int ATTR_PRIO    = 7;

    // Pixel word: {prio[5], pal[4:2], color[1:0]}; DMG keeps only color.
    localparam int PIX_COLOR_LSB = 0;
    localparam int PIX_PAL_LSB   = 2;
    localparam int PIX_PRIO      = 5;
    localparam int PIX_FULL_W    = 6;

    typedef struct packed {
        logic       prio;
        logic       yflip;
        logic       xflip;
        logic       bank;
        logic [2:0] pal;
    } tile_attr_t;

endpackage

// File: rtl/pixel_fifo_8w.sv
// Pixel FIFO with an 8-wide parallel push, single pop and synchronous flush.
// Writes are always 8-aligned because the write pointer only ever steps by 8.
module pixel_fifo_8w
    import gb_ppu_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int W     = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 flush_in,
    input  logic                 push_in,
    input  logic [7:0][W-1:0]    push_data_in,
    input  logic                 pop_in,
    output logic [W-1:0]         head_out,
    output logic [CNT_W-1:0]     count_out,
    output logic                 space8_out
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign space8_out = (count_q <= CNT_W'(DEPTH - 8));
    assign push_ok    = push_in && space8_out && !flush_in;
    assign pop_ok     = pop_in && (count_q != '0) && !flush_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok)
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 8)) ? '0 : wr_ptr_q + PTR_W'(8);
            if (pop_ok)
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            count_d = count_q + (push_ok ? CNT_W'(8) : '0) - (pop_ok ? CNT_W'(1) : '0);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            for (int i = 0; i < 8; i++)
                mem_q[wr_ptr_q + PTR_W'(i)] <= push_data_in[i];
        end
    end

    assign head_out  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_out = count_q;

endmodule

// File: rtl/tile_fetcher.sv
// BG/window tile fetcher with optional CGB attribute fetch, feeding a pixel FIFO.
// Every state change is qualified by the T-cycle enable tclk_in.
module tile_fetcher
    import gb_ppu_pkg::*;
#(
    parameter  int CGB_MODE   = 0,
    parameter  int FIFO_DEPTH = 16,
    localparam int PIX_W      = (CGB_MODE != 0) ? 6 : 2,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             tclk_in,
    input  logic             line_start_in,
    input  logic             window_trigger_in,
    input  logic [7:0]       LY_in,
    input  logic [7:0]       window_line_in,
    input  logic [7:0]       SCX_in,
    input  logic [7:0]       SCY_in,
    input  logic             bg_map_in,
    input  logic             win_map_in,
    input  logic             addr_mode_in,
    output logic [12:0]      rd_addr_out,
    output logic             rd_bank_out,
    output logic             rd_req_out,
    input  logic             rd_ack_in,
    input  logic [7:0]       rd_data_in,
    output logic             pix_valid_out,
    input  logic             pix_ready_in,
    output logic [PIX_W-1:0] pix_out,
    output logic [CNT_W-1:0] fifo_count_out
);

    fetch_state_e state_q, state_d;
    logic [4:0]   tile_x_q, tile_x_d;
    logic [2:0]   discard_q, discard_d;
    logic         in_window_q, in_window_d;
    logic         rd_req_q, rd_req_d;
    logic [12:0]  rd_addr_q, rd_addr_d;
    logic         rd_bank_q, rd_bank_d;
    logic [7:0]   tile_num_q, tile_num_d;
    tile_attr_t   attr_q, attr_d;
    logic [7:0]   lo_q, lo_d, hi_q, hi_d;

    logic [4:0]  map_x;
    logic [7:0]  line_y;
    logic [2:0]  row;
    logic [12:0] map_addr, tile_base, lo_addr, fetch_addr;
    logic        fetch_bank, data_bank;

    logic [CNT_W-1:0]      fifo_count;
    logic [PIX_W-1:0]      fifo_head;
    logic [7:0][PIX_W-1:0] push_pix;
    logic                  fifo_space8, fifo_push, fifo_pop, fifo_flush;
    logic                  pix_valid, drop, win_accept;

    always_comb begin
        map_x     = in_window_q ? tile_x_q : SCX_in[7:3] + tile_x_q;
        line_y    = in_window_q ? window_line_in : SCY_in + LY_in;
        map_addr  = ((in_window_q ? win_map_in : bg_map_in) ? MAP_BASE_1 : MAP_BASE_0)
                    + {3'b000, line_y[7:3], map_x};
        row       = attr_q.yflip ? ~line_y[2:0] : line_y[2:0];
        tile_base = addr_mode_in ? TILE_BASE_UNSIGN + {1'b0, tile_num_q, 4'b0000}
                                 : TILE_BASE_SIGNED + {tile_num_q[7], tile_num_q, 4'b0000};
        lo_addr   = tile_base + {9'b0, row, 1'b0};
        data_bank = (CGB_MODE != 0) ? attr_q.bank : 1'b0;
    end

    always_comb begin
        fetch_addr = map_addr;
        fetch_bank = 1'b0;
        case (state_q)
            ST_TILE_ATTR: fetch_bank = 1'b1;
            ST_DATA_LO: begin
                fetch_addr = lo_addr;
                fetch_bank = data_bank;
            end
            ST_DATA_HI: begin
                fetch_addr = lo_addr + 13'd1;
                fetch_bank = data_bank;
            end
            default: ;
        endcase
    end

    // Leftmost pixel goes in slot 0; xflip reads the bitplanes LSB-first.
    logic [2:0]            bsel;
    logic [PIX_FULL_W-1:0] full_pix;
    always_comb begin
        bsel     = '0;
        full_pix = '0;
        push_pix = '0;
        for (int i = 0; i < 8; i++) begin
            bsel     = attr_q.xflip ? 3'(i) : 3'(7 - i);
            full_pix = {attr_q.prio, attr_q.pal, hi_q[bsel], lo_q[bsel]};
            push_pix[i] = full_pix[PIX_W-1:0];
        end
    end

    assign win_accept = window_trigger_in && !in_window_q && !line_start_in;
    assign pix_valid  = (fifo_count != '0) && (discard_q == 3'd0);
    assign drop       = tclk_in && (discard_q != 3'd0) && (fifo_count != '0);
    assign fifo_pop   = (tclk_in && pix_valid && pix_ready_in) || drop;
    assign fifo_flush = tclk_in && (line_start_in || win_accept);
    assign fifo_push  = tclk_in && (state_q == ST_PUSH) && fifo_space8 && !fifo_flush;

    always_comb begin
        state_d     = state_q;
        tile_x_d    = tile_x_q;
        discard_d   = discard_q;
        in_window_d = in_window_q;
        rd_req_d    = rd_req_q;
        rd_addr_d   = rd_addr_q;
        rd_bank_d   = rd_bank_q;
        tile_num_d  = tile_num_q;
        attr_d      = attr_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        if (tclk_in) begin
            if (drop)
                discard_d = discard_q - 3'd1;
            if (line_start_in) begin
                state_d     = ST_TILE_NUM;
                tile_x_d    = '0;
                in_window_d = 1'b0;
                discard_d   = SCX_in[2:0];
                rd_req_d    = 1'b0;
            end else if (win_accept) begin
                state_d     = ST_TILE_NUM;
                tile_x_d    = '0;
                in_window_d = 1'b1;
                discard_d   = 3'd0;
                rd_req_d    = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_PUSH: begin
                        if (fifo_space8) begin
                            tile_x_d = tile_x_q + 5'd1;
                            state_d  = ST_TILE_NUM;
                        end
                    end
                    default: begin
                        // Request goes out on the first tick; the ack is only honoured afterwards.
                        if (!rd_req_q) begin
                            rd_req_d  = 1'b1;
                            rd_addr_d = fetch_addr;
                            rd_bank_d = fetch_bank;
                        end else if (rd_ack_in) begin
                            rd_req_d = 1'b0;
                            case (state_q)
                                ST_TILE_NUM: begin
                                    tile_num_d = rd_data_in;
                                    state_d    = (CGB_MODE != 0) ? ST_TILE_ATTR : ST_DATA_LO;
                                end
                                ST_TILE_ATTR: begin
                                    attr_d.prio  = rd_data_in[ATTR_PRIO];
                                    attr_d.yflip = rd_data_in[ATTR_YFLIP];
                                    attr_d.xflip = rd_data_in[ATTR_XFLIP];
                                    attr_d.bank  = rd_data_in[ATTR_BANK];
                                    attr_d.pal   = rd_data_in[ATTR_PAL_LSB +: 3];
                                    state_d      = ST_DATA_LO;
                                end
                                ST_DATA_LO: begin
                                    lo_d    = rd_data_in;
                                    state_d = ST_DATA_HI;
                                end
                                default: begin
                                    hi_d    = rd_data_in;
                                    state_d = ST_PUSH;
                                end
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            tile_x_q    <= '0;
            discard_q   <= '0;
            in_window_q <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            rd_bank_q   <= 1'b0;
            tile_num_q  <= '0;
            attr_q      <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
        end else begin
            state_q     <= state_d;
            tile_x_q    <= tile_x_d;
            discard_q   <= discard_d;
            in_window_q <= in_window_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            rd_bank_q   <= rd_bank_d;
            tile_num_q  <= tile_num_d;
            attr_q      <= attr_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
        end
    end

    pixel_fifo_8w #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W)
    ) u_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .flush_in     (fifo_flush),
        .push_in      (fifo_push),
        .push_data_in (push_pix),
        .pop_in       (fifo_pop),
        .head_out     (fifo_head),
        .count_out    (fifo_count),
        .space8_out   (fifo_space8)
    );

    assign rd_addr_out    = rd_addr_q;
    assign rd_bank_out    = rd_bank_q;
    assign rd_req_out     = rd_req_q;
    assign pix_valid_out  = pix_valid;
    assign pix_out        = fifo_head;
    assign fifo_count_out = fifo_count;

endmodule
